// File: rtl/axi_stream_slave_capture_if.sv
// AXI4-Stream beat bundle between an upstream source and the capture block.
interface axi_stream_slave_capture_if #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32
);
  logic                              s00_axis_tvalid;
  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata;
  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb;
  logic                              s00_axis_tlast;
  logic                              s00_axis_tready;

  modport master (
    output s00_axis_tvalid, s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast,
    input  s00_axis_tready
  );

  modport slave (
    input  s00_axis_tvalid, s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast,
    output s00_axis_tready
  );
endinterface

// File: rtl/axi_stream_slave_capture.sv
// AXI4-Stream sink: buffers {tlast, tdata} in a FIFO and tracks packet statistics.
module axi_stream_slave_capture #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16
) (
  input  logic                               s00_axis_aclk,
  input  logic                               s00_axis_areset,
  axi_stream_slave_capture_if.slave          s00_axis,
  input  logic                               hold,
  input  logic                               rd_en,
  output logic                               rd_valid,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]    rd_data,
  output logic                               rd_last,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic                               pkt_done,
  output logic [15:0]                        pkt_len,
  output logic [15:0]                        pkt_count,
  output logic                               strb_err
);
  localparam int DW = C_S_AXIS_TDATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t        r_state, w_state_nxt;
  logic [DW:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [15:0]   r_wcnt, r_pkt_len, r_pkt_count;
  logic          r_pkt_done, r_strb_err;

  logic          w_full, w_ready, w_accept, w_pop, w_last_accept;
  logic [15:0]   w_wcnt_inc;

  // Full blocks acceptance even when a pop lands on the same edge.
  assign w_full        = (r_level == LW'(FIFO_DEPTH));
  assign w_ready       = !s00_axis_areset && !hold && !w_full;
  assign w_accept      = s00_axis.s00_axis_tvalid && w_ready;
  assign w_pop         = rd_en && (r_level != '0);
  assign w_last_accept = w_accept && s00_axis.s00_axis_tlast;
  assign w_wcnt_inc    = (r_wcnt == '1) ? r_wcnt : r_wcnt + 16'd1;

  assign s00_axis.s00_axis_tready = w_ready;

  assign rd_valid   = (r_level != '0);
  assign rd_data    = r_mem[r_rd_ptr][DW-1:0];
  assign rd_last    = r_mem[r_rd_ptr][DW];
  assign fifo_level = r_level;
  assign pkt_done   = r_pkt_done;
  assign pkt_len    = r_pkt_len;
  assign pkt_count  = r_pkt_count;
  assign strb_err   = r_strb_err;

  always_ff @(posedge s00_axis_aclk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= {s00_axis.s00_axis_tlast, s00_axis.s00_axis_tdata};
    end
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && !s00_axis.s00_axis_tlast) w_state_nxt = S_RECV;
      S_RECV: if (w_last_accept)                        w_state_nxt = S_IDLE;
      default:                                          w_state_nxt = S_IDLE;
    endcase
  end

  // Statistics land one edge after the closing beat, together with the pulse.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      r_wcnt      <= '0;
      r_pkt_len   <= '0;
      r_pkt_count <= '0;
      r_pkt_done  <= 1'b0;
      r_strb_err  <= 1'b0;
    end else begin
      r_pkt_done <= w_last_accept;
      if (w_last_accept) begin
        r_wcnt      <= '0;
        r_pkt_len   <= w_wcnt_inc;
        r_pkt_count <= r_pkt_count + 16'd1;
      end else if (w_accept) begin
        r_wcnt <= w_wcnt_inc;
      end
      if (w_accept && (s00_axis.s00_axis_tstrb != '1)) begin
        r_strb_err <= 1'b1;
      end
    end
  end
endmodule

// File: doc/axi_stream_slave_capture.md
AXI_STREAM_SLAVE_CAPTURE -- requirements
Module: axi_stream_slave_capture

Interface
REQ-001 SHALL have parameter C_S_AXIS_TDATA_WIDTH, default 32, stream data width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, buffer depth in words; power of two, minimum 4.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port s00_axis_aclk, input, 1 bit, sole clock, rising edge.
REQ-005 SHALL have port s00_axis_areset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port s00_axis_tvalid, input, 1 bit, upstream beat valid.
REQ-007 SHALL have port s00_axis_tdata, input, C_S_AXIS_TDATA_WIDTH bits, beat data.
REQ-008 SHALL have port s00_axis_tstrb, input, C_S_AXIS_TDATA_WIDTH/8 bits, byte strobes.
REQ-009 SHALL have port s00_axis_tlast, input, 1 bit, last beat of packet.
REQ-010 SHALL have port s00_axis_tready, output, 1 bit, beat acceptance.
REQ-011 SHALL have port hold, input, 1 bit, forced backpressure.
REQ-012 SHALL have port rd_en, input, 1 bit, pop FIFO head.
REQ-013 SHALL have port rd_valid, output, 1 bit, FIFO not empty.
REQ-014 SHALL have port rd_data, output, C_S_AXIS_TDATA_WIDTH bits, FIFO head word.
REQ-015 SHALL have port rd_last, output, 1 bit, tlast stored with the head word.
REQ-016 SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1 bits, stored word count.
REQ-017 SHALL have port pkt_done, output, 1 bit, one-cycle pulse per completed packet.
REQ-018 SHALL have port pkt_len, output, 16 bits, word count of the last completed packet.
REQ-019 SHALL have port pkt_count, output, 16 bits, completed packet total.
REQ-020 SHALL have port strb_err, output, 1 bit, sticky partial-strobe flag.

Function
REQ-021 SHALL accept a beat when s00_axis_tvalid && s00_axis_tready at a rising clock edge.
REQ-022 SHALL drive s00_axis_tready combinationally as !hold && (fifo_level != FIFO_DEPTH), independent of s00_axis_tvalid.
REQ-023 SHALL write {tlast, tdata} of an accepted beat to the FIFO; the word SHALL appear on rd_data/rd_valid the following cycle (1-cycle latency).
REQ-024 SHALL pop the head when rd_en && rd_valid; rd_en on empty SHALL be ignored with no pointer or level change.
REQ-025 SHALL leave fifo_level unchanged on simultaneous accept and pop; otherwise +1 on accept, -1 on pop.
REQ-026 SHALL keep write/read pointers log2(FIFO_DEPTH) bits wide, wrapping modulo FIFO_DEPTH.
REQ-027 SHALL accept no beat when full, including full with a same-cycle pop; tready rises the cycle after the pop.
REQ-028 SHALL implement FSM IDLE/RECV: IDLE->RECV on accepted beat with tlast=0; RECV->IDLE on accepted beat with tlast=1; an accepted tlast=1 beat in IDLE SHALL stay IDLE (1-word packet).
REQ-029 SHALL count words per packet in a 16-bit counter: reset to 0 on packet completion, saturating at 16'hFFFF.
REQ-030 SHALL, on the cycle after an accepted tlast beat, pulse pkt_done for 1 cycle, load pkt_len with the packet word count (including the last beat), and increment pkt_count modulo 2^16.
REQ-031 SHALL set strb_err when an accepted beat has tstrb not all ones; strb_err SHALL hold until reset, and the beat SHALL still be stored.
REQ-032 SHALL have no effect from hold on the read side.

Reset
REQ-033 SHALL, while s00_axis_areset is high, force: pointers 0, fifo_level 0, rd_valid 0, FSM IDLE, word counter 0, pkt_done 0, pkt_len 0, pkt_count 0, strb_err 0.
REQ-034 SHALL hold s00_axis_tready at 0 while reset is asserted.
REQ-035 SHALL discard all buffered words and any partial packet on reset mid-packet, with no pkt_done; rd_data content after reset is don't-care.

Verification
REQ-036 SHALL cover: 4-beat packet 0x11,0x22,0x33,0x44 (tlast on 0x44), rd_en=0 -> fifo_level=4, pkt_done pulse, pkt_len=4, pkt_count=1.
REQ-037 SHALL cover: 20 beats continuous, FIFO_DEPTH=16, no reads -> tready low after 16th accept, fifo_level=16; one pop -> tready high next cycle, beat 17 accepted.
REQ-038 SHALL cover: 1-word packet with tlast=1 -> FSM stays IDLE, pkt_len=1, rd_last=1 on readout.
REQ-039 SHALL cover: simultaneous accept and pop at level 5 -> level stays 5, data order preserved across pointer wrap (>=40 words streamed).
REQ-040 SHALL cover: reset asserted after beat 2 of a 4-beat packet -> level 0, pkt_count 0, no pkt_done; next 2-beat packet -> pkt_len=2.
REQ-041 SHALL cover: accepted beat with tstrb=4'b0111 -> strb_err=1 and stays set; word still read back intact.
